// File: rtl/if_pipe_reg.sv
// IF/ID pipeline register with valid/ready handshake, flush and a 2-entry skid buffer.
// Optional stall counter output enabled by defining IF_PIPE_REG_STALL_CNT_EN.
module if_pipe_reg #(
  parameter int unsigned      PC_W      = 32,
  parameter int unsigned      INSTR_W   = 32,
  parameter logic [PC_W-1:0]    RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
`ifdef IF_PIPE_REG_STALL_CNT_EN
  ,
  parameter int unsigned      CNT_W     = 16
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  output logic               in_ready,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] instruction
`ifdef IF_PIPE_REG_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]   stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    main_pc_q, main_pc_d;
  logic [INSTR_W-1:0] main_instr_q, main_instr_d;
  logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               accept;
  logic               drain;

  assign accept = in_valid & in_ready_q;
  assign drain  = out_valid_q & out_ready & ~freeze;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    main_pc_d    = main_pc_q;
    main_instr_d = main_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;

    if (flush) begin
      // Held entries and any same-cycle accept are squashed; pc is left as is.
      state_d      = EMPTY;
      main_instr_d = NOP_INSTR;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_pc_d    = pc_in;
            main_instr_d = instr_in;
            state_d      = ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_pc_d    = pc_in;
            main_instr_d = instr_in;
          end else if (accept) begin
            skid_pc_d    = pc_in;
            skid_instr_d = instr_in;
            state_d      = TWO;
          end else if (drain) begin
            main_instr_d = NOP_INSTR;
            state_d      = EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            main_pc_d    = skid_pc_q;
            main_instr_d = skid_instr_q;
            state_d      = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    // Handshake outputs are registered from the next state so in_ready never
    // sees out_ready combinationally.
    in_ready_d  = (state_d != TWO);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= EMPTY;
      main_pc_q    <= RESET_PC;
      main_instr_q <= NOP_INSTR;
      skid_pc_q    <= RESET_PC;
      skid_instr_q <= NOP_INSTR;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      main_pc_q    <= main_pc_d;
      main_instr_q <= main_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign pc          = main_pc_q;
  assign instruction = main_instr_q;

`ifdef IF_PIPE_REG_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Counts cycles an entry waits at decode; saturates and survives flush.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_q && !drain && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_pipe_reg.sv
// Self-checking bench for if_pipe_reg: directed scenarios plus a FIFO scoreboard
// that checks every entry drained to decode.
module tb_if_pipe_reg;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned INSTR_W = 32;
  localparam logic [PC_W-1:0]    RST_PC = 32'h0000_0100;
  localparam logic [INSTR_W-1:0] NOP    = 32'h0000_0013;
`ifdef IF_PIPE_REG_STALL_CNT_EN
  localparam int unsigned CNT_W = 2;
`endif

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic               clk       = 1'b0;
  logic               rst       = 1'b1;
  logic               freeze    = 1'b0;
  logic               flush     = 1'b0;
  logic               in_valid  = 1'b0;
  logic [PC_W-1:0]    pc_in     = '0;
  logic [INSTR_W-1:0] instr_in  = '0;
  logic               out_ready = 1'b0;
  logic               in_ready;
  logic               out_valid;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] instruction;
`ifdef IF_PIPE_REG_STALL_CNT_EN
  logic [CNT_W-1:0]   stall_cnt;
`endif

  int passed = 0;
  int total  = 0;
  entry_t sb[$];

  always #5 clk = ~clk;

  if_pipe_reg #(
    .PC_W      (PC_W),
    .INSTR_W   (INSTR_W),
    .RESET_PC  (RST_PC),
    .NOP_INSTR (NOP)
`ifdef IF_PIPE_REG_STALL_CNT_EN
    ,
    .CNT_W     (CNT_W)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .flush       (flush),
    .in_valid    (in_valid),
    .pc_in       (pc_in),
    .instr_in    (instr_in),
    .in_ready    (in_ready),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .pc          (pc),
    .instruction (instruction)
`ifdef IF_PIPE_REG_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  // Inputs change only just after posedge, so values seen at negedge are what
  // the next posedge will act on.
  always @(negedge clk) begin
    entry_t exp;
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready && !freeze) begin
        total++;
        if (sb.size() == 0) begin
          $display("FAIL drain_order: got pc=%h instr=%h, required no drain (scoreboard empty)",
                   pc, instruction);
        end else begin
          exp = sb.pop_front();
          if (pc !== exp.pc || instruction !== exp.instr)
            $display("FAIL drain_order: got pc=%h instr=%h, required pc=%h instr=%h",
                     pc, instruction, exp.pc, exp.instr);
          else passed++;
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back('{pc: pc_in, instr: instr_in});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    freeze = 0; flush = 0; in_valid = 0; out_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic expect_outputs(string name, logic ov, logic ir,
                                logic [PC_W-1:0] epc, logic [INSTR_W-1:0] ein);
    total++;
    if (out_valid !== ov || in_ready !== ir || pc !== epc || instruction !== ein)
      $display("FAIL %s: got valid=%b ready=%b pc=%h instr=%h, required valid=%b ready=%b pc=%h instr=%h",
               name, out_valid, in_ready, pc, instruction, ov, ir, epc, ein);
    else passed++;
  endtask

  task automatic fill_two(logic [PC_W-1:0] p0, logic [PC_W-1:0] p1);
    out_ready = 0;
    in_valid = 1; pc_in = p0; instr_in = 32'hA000_0000 | p0;
    step();
    pc_in = p1; instr_in = 32'hA000_0000 | p1;
    step();
    in_valid = 0;
    expect_outputs("fill_two", 1'b1, 1'b0, p0, 32'hA000_0000 | p0);
  endtask

  task automatic test_reset();
    do_reset();
    expect_outputs("reset", 1'b0, 1'b1, RST_PC, NOP);
  endtask

  task automatic test_single();
    in_valid = 1; pc_in = 32'h4; instr_in = 32'h2008_0005; out_ready = 1;
    step();
    in_valid = 0;
    expect_outputs("single_latency", 1'b1, 1'b1, 32'h4, 32'h2008_0005);
    step();
    expect_outputs("single_empty", 1'b0, 1'b1, 32'h4, NOP);
  endtask

  task automatic test_stream();
    out_ready = 1;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1; pc_in = PC_W'(4 * i); instr_in = 32'h1100_0000 + INSTR_W'(i);
      step();
      expect_outputs("stream", 1'b1, 1'b1, PC_W'(4 * i), 32'h1100_0000 + INSTR_W'(i));
    end
    in_valid = 0;
    step();
    expect_outputs("stream_end", 1'b0, 1'b1, 32'hC, NOP);
  endtask

  task automatic test_freeze();
    out_ready = 1;
    in_valid = 1; pc_in = 32'h4; instr_in = 32'hB4;
    step();
    freeze = 1; pc_in = 32'h8; instr_in = 32'hB8;
    step();
    expect_outputs("freeze_skid", 1'b1, 1'b0, 32'h4, 32'hB4);
    pc_in = 32'hC; instr_in = 32'hBC;
    step();
    expect_outputs("freeze_hold1", 1'b1, 1'b0, 32'h4, 32'hB4);
    step();
    expect_outputs("freeze_hold2", 1'b1, 1'b0, 32'h4, 32'hB4);
    freeze = 0; in_valid = 0;
    step();
    expect_outputs("freeze_release", 1'b1, 1'b1, 32'h8, 32'hB8);
    step();
    expect_outputs("freeze_drained", 1'b0, 1'b1, 32'h8, NOP);
  endtask

  task automatic test_flush();
    fill_two(32'h4, 32'h8);
    flush = 1; in_valid = 1; pc_in = 32'hC; instr_in = 32'hC0C0;
    step();
    flush = 0; in_valid = 0;
    expect_outputs("flush", 1'b0, 1'b1, 32'h4, NOP);
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_outputs("flush_quiet", 1'b0, 1'b1, 32'h4, NOP);
    end
  endtask

  task automatic test_flush_drain();
    fill_two(32'h20, 32'h24);
    flush = 1; out_ready = 1;
    step();
    flush = 0;
    expect_outputs("flush_drain", 1'b0, 1'b1, 32'h20, NOP);
  endtask

  task automatic test_reset_two();
    fill_two(32'h40, 32'h44);
    rst = 1;
    step();
    rst = 0;
    expect_outputs("reset_two", 1'b0, 1'b1, RST_PC, NOP);
  endtask

  task automatic test_back_to_back();
    logic [PC_W-1:0] next_pc = 32'h1000;
    int waited = 0;
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      freeze    = ($urandom_range(4) == 0);
      flush     = ($urandom_range(19) == 0);
      pc_in     = next_pc;
      instr_in  = $urandom;
      step();
      if (in_valid && !flush) next_pc = next_pc + 32'h4;
    end
    idle_inputs();
    out_ready = 1;
    while (out_valid && waited < 8) begin
      step();
      waited++;
    end
    total++;
    if (out_valid !== 1'b0 || sb.size() != 0)
      $display("FAIL random_drain: got valid=%b pending=%0d, required valid=0 pending=0",
               out_valid, sb.size());
    else passed++;
  endtask

`ifdef IF_PIPE_REG_STALL_CNT_EN
  task automatic test_stall_cnt();
    logic [CNT_W-1:0] exp_cnt[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    in_valid = 1; pc_in = 32'h4; instr_in = 32'h55;
    step();
    in_valid = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (stall_cnt !== exp_cnt[i])
        $display("FAIL stall_cnt[%0d]: got %0d, required %0d", i, stall_cnt, exp_cnt[i]);
      else passed++;
    end
    flush = 1;
    step();
    flush = 0;
    total++;
    if (stall_cnt !== 2'd3) $display("FAIL stall_cnt_flush: got %0d, required 3", stall_cnt);
    else passed++;
    rst = 1;
    step();
    rst = 0;
    total++;
    if (stall_cnt !== 2'd0) $display("FAIL stall_cnt_rst: got %0d, required 0", stall_cnt);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_freeze();
    test_flush();
    test_flush_drain();
    test_reset_two();
    test_back_to_back();
`ifdef IF_PIPE_REG_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
